// File: rtl/arb_pkg.sv
// Shared types and line-address helpers for the prefetch-aware memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2,
    GNT_PF   = 2'd3
  } arb_grant_t;

  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & LINE_MASK;
  endfunction

  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & LINE_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/pf_mem_arbiter.sv
// Three-way arbiter (D-cache > I-cache > prefetch) onto one cacheline adaptor port;
// demand reads hitting the in-flight prefetch line piggyback on that transaction.
module pf_mem_arbiter
  import arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_read,
  input  logic [31:0]  icache_address,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [31:0]  dcache_address,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  arb_state_t   state_q, state_d;
  arb_grant_t   grant_q, grant_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic [255:0] line_q, line_d;
  logic         merge_i_q, merge_i_d;
  logic         merge_d_q, merge_d_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic         icache_resp_q, icache_resp_d;
  logic         dcache_resp_q, dcache_resp_d;
  logic         pf_resp_q, pf_resp_d;
  logic         hit_i_s;
  logic         hit_d_s;

  // Only reads may join an in-flight prefetch; writes always wait for IDLE.
  assign hit_i_s = (grant_q == GNT_PF) && icache_read && same_line(icache_address, addr_q);
  assign hit_d_s = (grant_q == GNT_PF) && dcache_read && same_line(dcache_address, addr_q);

  // Next-state logic: grant, issue, response pulse and merge tracking.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    line_d        = line_q;
    merge_i_d     = merge_i_q;
    merge_d_d     = merge_d_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    icache_resp_d = 1'b0;
    dcache_resp_d = 1'b0;
    pf_resp_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dcache_read || dcache_write) begin
          grant_d     = GNT_D;
          addr_d      = line_base(dcache_address);
          wdata_d     = dcache_wdata;
          mem_read_d  = ~dcache_write;
          mem_write_d = dcache_write;
          state_d     = ISSUE;
        end else if (icache_read) begin
          grant_d     = GNT_I;
          addr_d      = line_base(icache_address);
          wdata_d     = 256'd0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          state_d     = ISSUE;
        end else if (pf_read) begin
          grant_d     = GNT_PF;
          addr_d      = line_base(pf_address);
          wdata_d     = 256'd0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          state_d     = ISSUE;
        end else begin
          grant_d = GNT_NONE;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        merge_i_d = merge_i_q | hit_i_s;
        merge_d_d = merge_d_q | hit_d_s;
        if (mem_resp) begin
          line_d        = mem_rdata;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          icache_resp_d = (grant_q == GNT_I) | merge_i_d;
          dcache_resp_d = (grant_q == GNT_D) | merge_d_d;
          pf_resp_d     = (grant_q == GNT_PF);
          state_d       = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        grant_d   = GNT_NONE;
        merge_i_d = 1'b0;
        merge_d_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        grant_d     = GNT_NONE;
        merge_i_d   = 1'b0;
        merge_d_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= GNT_NONE;
      addr_q        <= 32'd0;
      wdata_q       <= 256'd0;
      line_q        <= 256'd0;
      merge_i_q     <= 1'b0;
      merge_d_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
      pf_resp_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      line_q        <= line_d;
      merge_i_q     <= merge_i_d;
      merge_d_q     <= merge_d_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      icache_resp_q <= icache_resp_d;
      dcache_resp_q <= dcache_resp_d;
      pf_resp_q     <= pf_resp_d;
    end
  end

  assign icache_rdata = line_q;
  assign dcache_rdata = line_q;
  assign pf_rdata     = line_q;
  assign icache_resp  = icache_resp_q;
  assign dcache_resp  = dcache_resp_q;
  assign pf_resp      = pf_resp_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;

endmodule
